// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 data mux between four requesters.
// Grants are held while requested, capped at MAX_HOLD cycles per turn.
module mux4_rr_arbiter #(
    parameter int unsigned DW       = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic          gnt_valid,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;

    logic          found_c;
    logic [1:0]    win_c;
    logic [1:0]    idx_c;
    logic          keep_c;
    logic [DW-1:0] mux_c;

    // First set request bit searching ptr, ptr+1, ... (mod 4)
    always_comb begin
        found_c = 1'b0;
        win_c   = ptr;
        idx_c   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx_c = ptr + 2'(i);
            if (!found_c && req[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    // Current owner may keep the path for another cycle
    always_comb begin
        keep_c = (state == GRANT) && req[sel] && (cnt < HOLD_MAX);
    end

    always_comb begin
        case (sel)
            2'd0:    mux_c = din0;
            2'd1:    mux_c = din1;
            2'd2:    mux_c = din2;
            default: mux_c = din3;
        endcase
    end

    // Arbitration state machine; every output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            sel       <= 2'b00;
            dout      <= '0;
            ptr       <= 2'b00;
            cnt       <= '0;
        end else begin
            dout <= gnt_valid ? mux_c : '0;
            if (keep_c) begin
                cnt <= cnt + CW'(1);
            end else if (found_c) begin
                // Covers IDLE pickup, hand-over, and self re-grant on timeout
                state     <= GRANT;
                gnt       <= 4'b0001 << win_c;
                gnt_valid <= 1'b1;
                sel       <= win_c;
                cnt       <= CW'(1);
                ptr       <= win_c + 2'd1;
            end else begin
                state     <= IDLE;
                gnt       <= 4'b0000;
                gnt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; four instances cover MAX_HOLD of 8, 4, 2 and 1.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       din0, din1, din2, din3;

    logic [3:0] gnt8, gnt4, gnt2, gnt1;
    logic       val8, val4, val2, val1;
    logic [1:0] sel8, sel4, sel2, sel1;
    logic       dout8, dout4, dout2, dout1;

    int total;
    int bad;

    mux4_rr_arbiter #(.DW(1), .MAX_HOLD(8)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt8), .gnt_valid(val8), .sel(sel8), .dout(dout8)
    );
    mux4_rr_arbiter #(.DW(1), .MAX_HOLD(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt4), .gnt_valid(val4), .sel(sel4), .dout(dout4)
    );
    mux4_rr_arbiter #(.DW(1), .MAX_HOLD(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt2), .gnt_valid(val2), .sel(sel2), .dout(dout2)
    );
    mux4_rr_arbiter #(.DW(1), .MAX_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt1), .gnt_valid(val1), .sel(sel1), .dout(dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then release between edges with req already applied
    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req   = r;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] e2;
        logic [1:0] e1;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        {din0, din1, din2, din3} = 4'b0000;

        // Held in reset with all requesters active
        tick();
        tick();
        chk("rst_gnt", 8'(gnt8), 8'h0);
        chk("rst_valid", 8'(val8), 8'h0);
        chk("rst_sel", 8'(sel8), 8'h0);
        chk("rst_dout", 8'(dout8), 8'h0);

        // Single requester 2 on MAX_HOLD=8
        req  = 4'b0100;
        din2 = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("single_gnt", 8'(gnt8), 8'h4);
        chk("single_sel", 8'(sel8), 8'h2);
        chk("single_valid", 8'(val8), 8'h1);
        chk("single_dout_lag", 8'(dout8), 8'h0);
        tick();
        chk("single_gnt_hold", 8'(gnt8), 8'h4);
        chk("single_dout", 8'(dout8), 8'h1);
        req = 4'b0000;
        tick();
        chk("drop_gnt", 8'(gnt8), 8'h0);
        chk("drop_valid", 8'(val8), 8'h0);
        chk("drop_sel_kept", 8'(sel8), 8'h2);
        chk("drop_dout_last", 8'(dout8), 8'h1);
        tick();
        chk("drop_dout_zero", 8'(dout8), 8'h0);

        // Full-load rotation: MAX_HOLD=2 pairs owners, MAX_HOLD=1 rotates every cycle
        {din0, din1, din2, din3} = 4'b1010;
        do_reset(4'b1111);
        for (int i = 0; i < 10; i++) begin
            tick();
            e2 = 2'((i / 2) % 4);
            e1 = 2'(i % 4);
            chk($sformatf("rot2_sel%0d", i), 8'(sel2), 8'(e2));
            chk($sformatf("rot2_valid%0d", i), 8'(val2), 8'h1);
            chk($sformatf("rot2_gnt%0d", i), 8'(gnt2), 8'(4'b0001 << e2));
            chk($sformatf("rot1_sel%0d", i), 8'(sel1), 8'(e1));
            if (i >= 1) begin
                // din0 and din2 are 1, din1 and din3 are 0
                chk($sformatf("rot2_dout%0d", i), 8'(dout2),
                    (((i - 1) / 2) % 2 == 0) ? 8'h1 : 8'h0);
            end
        end

        // Asynchronous reset while granted clears outputs before any edge
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 8'(gnt2), 8'h0);
        chk("async_valid", 8'(val2), 8'h0);
        chk("async_sel", 8'(sel2), 8'h0);
        chk("async_dout", 8'(dout2), 8'h0);
        tick();

        // Early release on MAX_HOLD=8: owner 0 drops after 3 cycles
        do_reset(4'b0011);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("early_own0_%0d", i), 8'(gnt8), 8'h1);
        end
        req = 4'b0010;
        tick();
        chk("early_switch", 8'(gnt8), 8'h2);
        req = 4'b0011;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("early_own1_%0d", i), 8'(gnt8), 8'h2);
        end
        tick();
        chk("early_timeout_to0", 8'(gnt8), 8'h1);

        // Timeout with no contention on MAX_HOLD=4: requester 3 kept, then requester 1 wins
        do_reset(4'b1000);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("to_gnt%0d", i), 8'(gnt4), 8'h8);
            chk($sformatf("to_valid%0d", i), 8'(val4), 8'h1);
        end
        req = 4'b1010;
        tick();
        chk("to_handover", 8'(gnt4), 8'h2);
        chk("to_handover_sel", 8'(sel4), 8'h1);

        // Pointer fairness on MAX_HOLD=2: after owner 1 times out, search starts at 2
        do_reset(4'b0010);
        tick();
        chk("fair_own1", 8'(sel2), 8'h1);
        req = 4'b0011;
        tick();
        chk("fair_own1_hold", 8'(sel2), 8'h1);
        tick();
        chk("fair_to0", 8'(sel2), 8'h0);
        tick();
        chk("fair_own0_hold", 8'(sel2), 8'h0);
        tick();
        chk("fair_back1", 8'(sel2), 8'h1);

        // Simultaneous requests with ptr=2 pick requester 3
        do_reset(4'b0010);
        tick();
        req = 4'b1011;
        tick();
        tick();
        chk("simul_ptr2", 8'(gnt2), 8'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single 4:1 multiplexer path between four requesters. It samples a 4-bit request vector and grants exactly one requester at a time. It drives the mux select from the grant and registers the selected data word. Each grant is held for as long as the owner keeps requesting, bounded by a programmable maximum burst length, so no requester can starve the others.

Parameters:
DW, 1, data width of each input word and of dout
MAX_HOLD, 8, maximum consecutive cycles one owner may hold a grant (legal range 1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request vector, bit i = requester i wants the path
din0  input  DW  data from requester 0
din1  input  DW  data from requester 1
din2  input  DW  data from requester 2
din3  input  DW  data from requester 3
gnt  output  4  one-hot grant, registered
gnt_valid  output  1  high when any gnt bit set, registered
sel  output  2  mux select = index of current owner, registered
dout  output  DW  registered mux output

Behaviour:
- Reset (rst_n low, asynchronous): gnt=4'b0000, gnt_valid=0, sel=2'b00, dout=0, round-robin pointer ptr=0, hold counter cnt=0, state=IDLE. Assertion mid-grant aborts the grant immediately, with no completion cycle. First arbitration happens on the first rising edge after rst_n deasserts.
- State IDLE: gnt_valid=0. On an edge where req!=0, the arbiter picks the winner as the first set bit searching ptr, ptr+1, ... mod 4. At that edge: gnt=onehot(winner), sel=winner, gnt_valid=1, cnt=1, ptr=winner+1 mod 4, state=GRANT. On an edge where req==0, it stays in IDLE.
- Latency: a request sampled at edge k produces a grant visible after edge k (1 cycle).
- State GRANT, with owner o = sel:
  - Continue: req[o]=1 and cnt<MAX_HOLD. Grant is held and cnt increments.
  - Release: req[o]=0, or cnt==MAX_HOLD.
- On release, re-arbitrate at the same edge using the updated ptr (o+1):
  - If any other bit is set, grant the next winner directly, back-to-back with no idle cycle, and set cnt=1.
  - If only req[o] is set (timeout with no contention), re-grant o, restart cnt=1, and set ptr=o+1.
  - If req==0, set gnt=0, gnt_valid=0, state=IDLE. sel keeps its last value.
- req[o] dropping while others are pending: the next owner is granted at that edge; there is no dead cycle.
- Simultaneous requests: resolved purely by ptr order. Example: ptr=2, req=4'b1011 → grant requester 3.
- MAX_HOLD=1: every grant lasts exactly one cycle, giving strict rotation under full load.
- cnt width is 8 bits. cnt never exceeds MAX_HOLD, so there is no wrap.
- dout: at each edge, dout <= gnt_valid ? din[sel] : 0, using the current (pre-edge) registered sel/gnt_valid. dout therefore lags the grant by 1 cycle and is 0 the cycle after the arbiter enters IDLE.
- gnt is always one-hot or zero. gnt_valid == |gnt at all times. sel == index(gnt) whenever gnt_valid=1.
- req bits are ignored while not owner except at arbitration edges. A requester that pulses req for a cycle between arbitration points is never granted.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, gnt_valid=0, sel=0, dout=0. Drop rst_n=0 asynchronously mid-grant → all outputs 0 immediately, before the next edge.
- Single requester: req=4'b0100, din2=1, others 0, MAX_HOLD=8 → gnt=4'b0100 and sel=2 one cycle later, dout=1 one cycle after that. Drop req → gnt=0 next edge, dout=0 the following edge.
- Full-load rotation: req=4'b1111, MAX_HOLD=2 after reset → owners 0,0,1,1,2,2,3,3,0,… with no gaps, gnt_valid constantly 1.
- Early release: req=4'b0011 with owner 0 → drop req[0] after 3 grant cycles → gnt switches to 4'b0010 at that same edge, cnt restarts, owner 1 holds up to 8 cycles.
- Timeout, no contention: req=4'b1000, MAX_HOLD=4 → gnt stays 4'b1000 continuously and ptr=0 after each re-grant. Then raise req[1] during the 4th cycle → requester 1 granted at the next edge.
- Pointer fairness: owner 1 releases with req=4'b0011 → requester 0 is not granted before requester 1's next slot is skipped. Expected grant sequence 0 then 1, confirming search starts at ptr=2.
